// File: rtl/debug_mem_dump.sv
// debug_mem_dump - UART debug memory reader.
//
// A host sends a 4-byte command {OPCODE, ADDR_HI, ADDR_LO, LEN}. The opcode
// selects one of NUM_CH memories (CMD_BASE+c). The block then reads LEN
// bytes (LEN=0 -> 256) from the shared debug bus, starting at the given
// address, and streams them out over the UART TX handshake. A header that
// stalls for TIMEOUT_CYC idle clocks between bytes is abandoned.
//
// Optional feature (macro DBG_CHECKSUM_EN): after the last data byte, one
// extra byte is sent that holds the XOR of all data bytes of the command.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rx_data       received UART byte
//   rx_ready      UART RX valid level (new byte = rising edge)
//   dbg_addr      shared read address (holds its value while idle)
//   dbg_ch        selected memory channel (holds its value while idle)
//   dbg_rd_en     one-cycle read strobe
//   dbg_rd_data   read data, channel c in bits [8c+7:8c], RD_LAT cycles late
//   tx_data       byte to transmit
//   tx_send       one-cycle transmit strobe, only while tx_busy=0
//   tx_busy       UART TX busy
//   busy          high whenever the block is not idle
module debug_mem_dump #(
    parameter int         NUM_CH      = 4,
    parameter int         ADDR_W      = 12,
    parameter int         RD_LAT      = 1,
    parameter logic [7:0] CMD_BASE    = 8'hD0,
    parameter int         TIMEOUT_CYC = 1000000,
    localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_ready,
    output logic [ADDR_W-1:0]   dbg_addr,
    output logic [CH_W-1:0]     dbg_ch,
    output logic                dbg_rd_en,
    input  logic [NUM_CH*8-1:0] dbg_rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_send,
    input  logic                tx_busy,
    output logic                busy
);

    localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    // Last LAT-state count before capture; not used when RD_LAT=0.
    localparam logic [2:0]      LAT_LAST = 3'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_HDR_LEN,
        S_RD,
        S_LAT,
        S_SEND,
        S_WB_HI,
        S_WB_LO
`ifdef DBG_CHECKSUM_EN
        , S_CKSUM
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                rx_q;
    logic [TO_W-1:0]     to_q, to_d;
    logic [CH_W-1:0]     ch_stg_q, ch_stg_d;
    logic [7:0]          addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0]   addr_stg_q, addr_stg_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [8:0]          cnt_q, cnt_d;
    logic [2:0]          lat_q, lat_d;
    logic [1:0]          wb_q, wb_d;
    logic [7:0]          txd_q, txd_d;
`ifdef DBG_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
    logic                ck_q, ck_d;   // current SEND carries the checksum
`endif

    logic       byte_stb;
    logic [8:0] op_off;
    logic       op_ok;
    logic [7:0] rd_byte;
    logic       cap;

    assign byte_stb = rx_ready & ~rx_q;
    // 9-bit difference: bit 8 set means the byte is below CMD_BASE.
    assign op_off   = {1'b0, rx_data} - {1'b0, CMD_BASE};
    assign op_ok    = ~op_off[8] && (op_off < 9'(NUM_CH));
    assign rd_byte  = dbg_rd_data[{ch_q, 3'b000} +: 8];

    assign dbg_addr = addr_q;
    assign dbg_ch   = ch_q;
    assign tx_data  = txd_q;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        to_d       = to_q;
        ch_stg_d   = ch_stg_q;
        addr_hi_d  = addr_hi_q;
        addr_stg_d = addr_stg_q;
        addr_d     = addr_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        wb_d       = wb_q;
        txd_d      = txd_q;
`ifdef DBG_CHECKSUM_EN
        xor_d      = xor_q;
        ck_d       = ck_q;
`endif
        dbg_rd_en  = 1'b0;
        tx_send    = 1'b0;
        cap        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (byte_stb && op_ok) begin
                    ch_stg_d = op_off[CH_W-1:0];
                    to_d     = '0;
`ifdef DBG_CHECKSUM_EN
                    xor_d    = 8'h00;
`endif
                    state_d  = S_HDR_HI;
                end
            end
            S_HDR_HI, S_HDR_LO, S_HDR_LEN: begin
                if (byte_stb) begin
                    to_d = '0;
                    if (state_q == S_HDR_HI) begin
                        addr_hi_d = rx_data;
                        state_d   = S_HDR_LO;
                    end else if (state_q == S_HDR_LO) begin
                        // 16-bit host address truncated to the bus width.
                        addr_stg_d = ADDR_W'({addr_hi_q, rx_data});
                        state_d    = S_HDR_LEN;
                    end else begin
                        // Commit only a complete header, so an abandoned
                        // command leaves dbg_addr/dbg_ch untouched.
                        addr_d  = addr_stg_q;
                        ch_d    = ch_stg_q;
                        cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
`ifdef DBG_CHECKSUM_EN
                        ck_d    = 1'b0;
`endif
                        state_d = S_RD;
                    end
                end else if (to_q == TO_LAST) begin
                    to_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_RD: begin
                dbg_rd_en = 1'b1;
                if (RD_LAT == 0) begin
                    cap     = 1'b1;
                    state_d = S_SEND;
                end else begin
                    lat_d   = 3'd0;
                    state_d = S_LAT;
                end
            end
            S_LAT: begin
                if (lat_q == LAT_LAST) begin
                    cap     = 1'b1;
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_send = 1'b1;
                    wb_d    = 2'd0;
                    state_d = S_WB_HI;
                end
            end
            S_WB_HI: begin
                // A TX that never raises busy must not hang the block.
                if (tx_busy || wb_q == 2'd3) state_d = S_WB_LO;
                else                         wb_d    = wb_q + 2'd1;
            end
            S_WB_LO: begin
                if (!tx_busy) begin
`ifdef DBG_CHECKSUM_EN
                    if (ck_q) begin
                        state_d = S_IDLE;
                    end else
`endif
                    if (cnt_q != 9'd1) begin
                        cnt_d   = cnt_q - 9'd1;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_RD;
                    end else begin
                        cnt_d   = 9'd0;
`ifdef DBG_CHECKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
`ifdef DBG_CHECKSUM_EN
            S_CKSUM: begin
                txd_d   = xor_q;
                ck_d    = 1'b1;
                state_d = S_SEND;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (cap) begin
            txd_d = rd_byte;
`ifdef DBG_CHECKSUM_EN
            xor_d = xor_q ^ rd_byte;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rx_q       <= 1'b0;
            to_q       <= '0;
            ch_stg_q   <= '0;
            addr_hi_q  <= '0;
            addr_stg_q <= '0;
            addr_q     <= '0;
            ch_q       <= '0;
            cnt_q      <= '0;
            lat_q      <= '0;
            wb_q       <= '0;
            txd_q      <= '0;
`ifdef DBG_CHECKSUM_EN
            xor_q      <= '0;
            ck_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_q       <= rx_ready;
            to_q       <= to_d;
            ch_stg_q   <= ch_stg_d;
            addr_hi_q  <= addr_hi_d;
            addr_stg_q <= addr_stg_d;
            addr_q     <= addr_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            wb_q       <= wb_d;
            txd_q      <= txd_d;
`ifdef DBG_CHECKSUM_EN
            xor_q      <= xor_d;
            ck_q       <= ck_d;
`endif
        end
    end

endmodule
